// File: rtl/link_ram_rx.sv
// Receive side of the 4-wire ROM link: resynchronise, sample on link-clock fall, fill/show a RAM.
// Optional link watchdog enabled by defining LINK_TIMEOUT_EN.
module link_ram_rx #(
  parameter int ADDR_W         = 4,
  parameter int DATA_W         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_link_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] leds,
  output logic              o_wr_led,
  output logic              o_frame_done,
  output logic              o_seq_err,
  output logic              o_link_lost,
  output logic [1:0]        o_dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [SYNC_STAGES-1:0]             r_sync_clk;
  logic [SYNC_STAGES-1:0]             r_sync_we;
  logic [SYNC_STAGES-1:0][ADDR_W-1:0] r_sync_addr;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync_data;
  logic                               r_link_prev;
  logic                               w_link_clk_s;
  logic                               w_strobe;

  // Sample handshake: r_sample_v is a one-cycle valid qualifying r_s_we/r_s_addr/r_s_data;
  // there is no ready, the FSM must consume the sample in the cycle it is valid.
  logic              r_sample_v;
  logic              r_s_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_data;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_do_write;
  logic              w_do_read;
  logic              w_check;
  logic              w_timeout;

  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_leds;
  logic [ADDR_W-1:0] r_exp_addr;
  logic              r_seq_err;
  logic              r_frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_clk  <= '0;
      r_sync_we   <= '0;
      r_sync_addr <= '0;
      r_sync_data <= '0;
      r_link_prev <= 1'b0;
    end else begin
      r_sync_clk  <= {r_sync_clk[SYNC_STAGES-2:0], i_link_clk};
      r_sync_we   <= {r_sync_we[SYNC_STAGES-2:0], i_wr_en};
      r_sync_addr <= {r_sync_addr[SYNC_STAGES-2:0], i_addr};
      r_sync_data <= {r_sync_data[SYNC_STAGES-2:0], i_data};
      r_link_prev <= w_link_clk_s;
    end
  end

  // The sender moves the bus on the rising edge, so the falling edge is mid-bit.
  assign w_link_clk_s = r_sync_clk[SYNC_STAGES-1];
  assign w_strobe     = r_link_prev & ~w_link_clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_v <= 1'b0;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_data   <= '0;
    end else begin
      r_sample_v <= w_strobe;
      if (w_strobe) begin
        r_s_we   <= r_sync_we[SYNC_STAGES-1];
        r_s_addr <= r_sync_addr[SYNC_STAGES-1];
        r_s_data <= r_sync_data[SYNC_STAGES-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_do_write   = 1'b0;
    w_do_read    = 1'b0;
    w_check      = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (r_sample_v) begin
      unique case (r_state)
        S_IDLE: begin
          if (r_s_addr == '0) begin
            w_state_next = r_s_we ? S_LOAD : S_SHOW;
            w_do_write   = r_s_we;
            w_do_read    = ~r_s_we;
          end
        end
        S_LOAD, S_SHOW: begin
          // Mode follows wr_en on every sample, including on the wrap sample.
          w_state_next = r_s_we ? S_LOAD : S_SHOW;
          w_do_write   = r_s_we;
          w_do_read    = ~r_s_we;
          w_check      = 1'b1;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_ram[r_s_addr] <= r_s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= '0;
      r_leds       <= '0;
      r_exp_addr   <= '0;
      r_seq_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_timeout) begin
        r_valid <= '0;
        r_leds  <= '0;
      end else begin
        if (w_do_write) begin
          r_valid[r_s_addr] <= 1'b1;
          r_leds            <= r_s_data;
          r_frame_done      <= (r_s_addr == ADDR_W'(DEPTH - 1));
        end else if (w_do_read) begin
          r_leds <= r_valid[r_s_addr] ? r_ram[r_s_addr] : '0;
        end
        if (w_do_write || w_do_read) begin
          r_exp_addr <= r_s_addr + ADDR_W'(1);
        end
        if (w_check && (r_s_addr != r_exp_addr)) begin
          r_seq_err <= 1'b1;
        end
      end
    end
  end

`ifdef LINK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_link_lost;

  // The counter parks at its terminal value once the link is declared lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt    <= '0;
      r_link_lost <= 1'b0;
    end else if (w_strobe) begin
      r_to_cnt    <= '0;
      r_link_lost <= 1'b0;
    end else if (!r_link_lost) begin
      if (w_timeout) begin
        r_link_lost <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
    end
  end

  assign w_timeout   = ~w_strobe & ~r_link_lost & (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_link_lost = r_link_lost;
`else
  assign w_timeout   = 1'b0;
  assign o_link_lost = 1'b0;
`endif

  assign leds         = r_leds;
  assign o_wr_led     = (r_state == S_LOAD);
  assign o_frame_done = r_frame_done;
  assign o_seq_err    = r_seq_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_link_ram_rx.sv
// Bench for link_ram_rx: link driver tasks, sample-level reference model, queue-based scoreboard.
// Define LINK_TIMEOUT_EN for both files to exercise the watchdog (bench sets TIMEOUT_CYCLES=100).
module tb_link_ram_rx;

  localparam int AW  = 4;
  localparam int DW  = 4;
  localparam int SS  = 2;
  localparam int TO  = 100;
  localparam int LAT = SS + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          link_clk = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] leds;
  logic          wr_led;
  logic          frame_done;
  logic          seq_err;
  logic          link_lost;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int n_pushed = 0;
  int n_done = 0;

  // Expected record: {prev_leds[11:8], lost[7], wr_led[6], seq_err[5], frame[4], leds[3:0]}
  logic [11:0] exp_q[$];

  // Reference model state, kept at the level of one link sample.
  int          m_mode;   // 0 waiting for address 0, 1 writing, 2 reading
  int          m_exp;
  logic [DW-1:0] m_ram[16];
  bit          m_valid[16];
  bit          m_seq;
  bit          m_lost;
  logic [DW-1:0] m_leds;

  // clock/reset block
  always #5 clk = ~clk;

  link_ram_rx #(
    .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_link_clk(link_clk), .i_wr_en(wr_en),
    .i_addr(addr), .i_data(data), .leds(leds), .o_wr_led(wr_led),
    .o_frame_done(frame_done), .o_seq_err(seq_err), .o_link_lost(link_lost),
    .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_exp  = 0;
    m_seq  = 1'b0;
    m_lost = 1'b0;
    m_leds = '0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  function automatic logic [11:0] model_sample(input bit we, input int a, input logic [DW-1:0] d);
    logic [DW-1:0] prev;
    bit frame;
    bit act;
    prev   = m_leds;
    frame  = 1'b0;
    act    = 1'b1;
    m_lost = 1'b0;
    if (m_mode == 0) begin
      if (a != 0) act = 1'b0;
    end else if (a != m_exp) begin
      m_seq = 1'b1;
    end
    if (act) begin
      m_mode = we ? 1 : 2;
      if (we) begin
        m_ram[a]   = d;
        m_valid[a] = 1'b1;
        m_leds     = d;
        frame      = (a == 15);
      end else begin
        m_leds = m_valid[a] ? m_ram[a] : '0;
      end
      m_exp = (a + 1) % 16;
    end
    return {prev, m_lost, (m_mode == 1), m_seq, frame, m_leds};
  endfunction

  // driver: one full link period, falling edge placed on a local negedge
  task automatic send(input bit we, input int a, input logic [DW-1:0] d, input int hi, input int lo);
    @(negedge clk);
    link_clk = 1'b1;
    wr_en    = we;
    addr     = a[AW-1:0];
    data     = d;
    repeat (hi - 1) @(negedge clk);
    link_clk = 1'b0;
    exp_q.push_back(model_sample(we, a, d));
    n_pushed++;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_leds"}, leds, 0);
    check({tag, "_wr_led"}, wr_led, 0);
    check({tag, "_frame"}, frame_done, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_link_lost"}, link_lost, 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    link_clk = 1'b0;
    wr_en    = 1'b0;
    addr     = '0;
    data     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [11:0] e;
    forever begin
      wait (n_pushed > n_done);
      e = exp_q.pop_front();
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk);
      check("leds_before_latency", leds, e[11:8]);
      @(negedge clk);
      check("leds", leds, e[3:0]);
      check("frame_done", frame_done, e[4]);
      check("seq_err", seq_err, e[5]);
      check("wr_led", wr_led, e[6]);
      check("link_lost", link_lost, e[7]);
      @(negedge clk);
      check("frame_pulse_end", frame_done, 0);
      n_done++;
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    n_err++;
    $display("FAIL watchdog: got timeout expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : stimulus
    int aa;
    model_reset();
    do_reset();

    // full write sweep, data = addr
    for (int a = 0; a < 16; a++) send(1'b1, a, DW'(a), 20, 20);
    // read it back
    for (int a = 0; a < 16; a++) send(1'b0, a, DW'(15 - a), 20, 20);

    // start mid-frame: ignored until address 0; then read before any write
    do_reset();
    for (int a = 5; a < 16; a++) send(1'b1, a, DW'($urandom_range(0, 15)), 20, 20);
    for (int a = 0; a < 16; a++) send(1'b0, a, '0, 20, 20);

    // skipped address 3 while writing
    for (int a = 0; a < 16; a++) begin
      if (a != 3) send(1'b1, a, DW'($urandom_range(0, 15)), 20, 20);
    end
    for (int a = 0; a < 16; a++) send(1'b0, a, '0, 20, 20);

    // reset in the middle of a write sweep at address 7
    for (int a = 0; a < 7; a++) send(1'b1, a, DW'(a ^ 5), 20, 20);
    @(negedge clk);
    link_clk = 1'b1;
    wr_en    = 1'b1;
    addr     = 4'd7;
    data     = 4'd2;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    link_clk = 1'b0;
    exp_q.push_back(model_sample(1'b1, 7, 4'd2));
    n_pushed++;
    repeat (20) @(negedge clk);
    for (int a = 8; a < 16; a++) send(1'b1, a, DW'(a), 20, 20);
    for (int a = 0; a < 16; a++) send(1'b1, a, DW'(~a), 20, 20);
    for (int a = 0; a < 16; a++) send(1'b0, a, '0, 20, 20);

    // randomized sweeps: random mode switches, data, occasional address jumps
    for (int s = 0; s < 6; s++) begin
      for (int a = 0; a < 16; a++) begin
        aa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : a;
        send(1'($urandom_range(0, 1)), aa, DW'($urandom_range(0, 15)),
             $urandom_range(8, 25), $urandom_range(8, 25));
      end
    end

`ifdef LINK_TIMEOUT_EN
    do_reset();
    for (int a = 0; a < 16; a++) send(1'b1, a, DW'(a), 20, 20);
    repeat (75) @(negedge clk);
    check("lost_before_timeout", link_lost, 0);
    repeat (15) @(negedge clk);
    check("lost_after_timeout", link_lost, 1);
    check("leds_after_timeout", leds, 0);
    check("wr_led_after_timeout", wr_led, 0);
    m_mode = 0;
    m_leds = '0;
    m_lost = 1'b1;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    for (int a = 0; a < 16; a++) send(1'b0, a, '0, 20, 20);
    for (int a = 0; a < 16; a++) send(1'b1, a, DW'(15 - a), 20, 20);
    for (int a = 0; a < 16; a++) send(1'b0, a, '0, 20, 20);
`endif

    for (int i = 0; i < 200 && n_done < n_pushed; i++) @(negedge clk);
    check("scoreboard_drained", 8'(n_pushed - n_done), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/link_ram_rx.md
Name: link_ram_rx

Overview:
- Receiving-side stage on the second FPGA. Consumes the 4-wire link driven by the ROM sender: link clock, write enable, 4-bit address and 4-bit data.
- Resynchronises the link into the local 100 MHz domain, samples it once per link period, writes a 16x4 RAM during write sweeps, and shows RAM contents on LEDs during read sweeps.
- Flags address-sequence errors and completed write frames.

Parameters:
- ADDR_W, 4, link address width; RAM depth = 2**ADDR_W.
- DATA_W, 4, link/RAM data width.
- SYNC_STAGES, 2, flops per synchroniser on every link input (minimum 2).
- TIMEOUT_CYCLES, 150_000_000, local clocks with no link sample before link-lost (used only with LINK_TIMEOUT_EN).

Ports:
- clk  in  1  local 100 MHz clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_link_clk  in  1  remote 1 Hz link clock; asynchronous to clk.
- i_wr_en  in  1  remote write enable.
- i_addr  in  ADDR_W  remote address.
- i_data  in  DATA_W  remote data.
- leds  out  DATA_W  displayed data.
- o_wr_led  out  1  high while FSM in S_LOAD.
- o_frame_done  out  1  one-clk pulse when address 15 is written.
- o_seq_err  out  1  sticky address-sequence error.
- o_link_lost  out  1  watchdog flag.

Behaviour:
- Reset: all outputs 0; all synchroniser flops 0; FSM S_IDLE; expected address 0; RAM contents undefined; valid mask cleared.
- Synchronisation:
  - Every link input passes through SYNC_STAGES flops.
  - A one-clk sample strobe fires on the falling edge of the synchronised link clock (edge register compares current vs previous).
  - The sender changes the bus on the rising edge, so the falling edge is the mid-period stable point.
- Capture: on the strobe, synchronised wr_en/addr/data are registered as s_we/s_addr/s_data. All actions below occur in that strobe cycle.
- Latency: pin falling edge to RAM write / leds update = SYNC_STAGES+2 clk cycles.
- FSM states:
  - S_IDLE: ignore samples until s_addr==0. On that sample, go to S_LOAD if s_we=1, else S_SHOW, and process the sample in that same cycle.
  - S_LOAD: ram[s_addr]<=s_data; valid[s_addr]<=1; leds<=s_data. If s_we=0, move to S_SHOW and treat the sample as a read.
  - S_SHOW: leds<=ram[s_addr] when valid[s_addr]=1, else 0. If s_we=1, move to S_LOAD and treat the sample as a write.
- Sequence check (S_LOAD/S_SHOW only):
  - Expected address = previous s_addr+1, wrapping 15->0.
  - On mismatch, set o_seq_err (sticky until reset); still execute the access; resync expected to s_addr+1.
- o_frame_done: one-clk pulse on a write to address 2**ADDR_W-1.
- o_wr_led = (state==S_LOAD).
- Simultaneous wr_en change with wrap: allowed. The mode switch takes effect on the same sample.
- Reset mid-sweep: return to S_IDLE; wait for the next address-0 sample.
- Glitch rule: at least 2 clks between strobes is guaranteed by the synchroniser. Link-clock pulses shorter than SYNC_STAGES clks need not be captured.

Optional Feature:
- Macro: LINK_TIMEOUT_EN.
- Enabled:
  - A counter of clks since the last strobe runs; a strobe clears it.
  - At TIMEOUT_CYCLES, set o_link_lost, force S_IDLE, clear the valid mask, drive leds 0, and stop counting.
  - o_link_lost clears on the next strobe.
- Disabled: no counter logic; o_link_lost tied 0.

Test Plan:
- Reset, then full write sweep (link period 40 clks, wr_en=1, addr/data 0..15 with data=addr): RAM[i]==i; leds track data SYNC_STAGES+2 clks after each falling edge; o_frame_done one pulse at addr 15; o_seq_err=0.
- Write sweep, then read sweep (wr_en=0, addr 0..15): leds = 0,1,...,F in order; o_wr_led 1 during write sweep, 0 during read.
- Start link at addr 5 after reset: FSM stays S_IDLE, leds 0 until addr 0 arrives. Read sweep before any write shows leds 0 (valid mask clear).
- Skip address (sequence 0,1,2,4): o_seq_err rises at the addr-4 sample and stays high; RAM[4] still written.
- Assert rst_n low at addr 7 of a write sweep, release: outputs 0; capture restarts at next addr 0; o_seq_err 0.
- LINK_TIMEOUT_EN, TIMEOUT_CYCLES=100: stop link after a write sweep. o_link_lost=1 at 100 clks; leds 0. Resume link: flag clears on first strobe; read sweep shows 0 until rewritten.
